// File: rtl/sigmon_event_collector.sv
// sigmon_event_collector: round-robin drain of N_MON monitor FIFOs onto a tagged 40-bit valid/ready stream.
// Optional read-response watchdog is compiled in with SIGMON_COLLECT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing to do, or collection disabled
// ARB   | pick next eligible monitor from rr_ptr onward
// READ  | issue one FIFO read once the output slot is free
// WAIT  | wait for the selected monitor's read response
// NEXT  | decide: continue burst, rotate, or stop
module sigmon_event_collector #(
    parameter int N_MON   = 4,
    parameter int BURST   = 8,
    parameter int TIMEOUT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  collect_en,
    input  logic [36*N_MON-1:0]   mon_data,
    input  logic [11*N_MON-1:0]   mon_count,
    input  logic [N_MON-1:0]      mon_valid,
    input  logic [N_MON-1:0]      mon_loss,
    output logic [N_MON-1:0]      mon_read,
    output logic [39:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_MON-1:0]      loss_vec,
    output logic [31:0]           word_cnt,
    output logic                  err_timeout
);
    localparam int BC_W = $clog2(BURST + 1);

    typedef enum logic [2:0] {IDLE, ARB, READ, WAIT, NEXT} state_t;

    if (N_MON < 1 || N_MON > 16) begin : g_bad_n_mon
        $error("sigmon_event_collector: N_MON must be in 1..16");
    end
    if (BURST < 1 || TIMEOUT < 1) begin : g_bad_limits
        $error("sigmon_event_collector: BURST and TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic [3:0]          sel_q, sel_d;
    logic [3:0]          rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [39:0]         out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [N_MON-1:0]    loss_q, loss_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic                collect_en_q;

    logic [N_MON-1:0]    elig, elig_rot, sel_oh;
    logic [2*N_MON-1:0]  elig_dbl;
    logic [36*N_MON-1:0] data_sh;
    logic                arb_found;
    logic [3:0]          arb_off, arb_idx, sel_inc;
    logic [4:0]          arb_sum;
    logic                sel_valid, sel_elig, rsp_timeout;

    for (genvar i = 0; i < N_MON; i++) begin : g_elig
        assign elig[i] = |mon_count[11*i +: 11];
    end

    // Rotate eligibility so bit 0 is rr_ptr; first set bit is the grant offset.
    assign elig_dbl = {elig, elig} >> rr_ptr_q;
    assign elig_rot = elig_dbl[N_MON-1:0];

    always_comb begin
        arb_found = 1'b0;
        arb_off   = '0;
        for (int k = 0; k < N_MON; k++) begin
            if (!arb_found && elig_rot[k]) begin
                arb_found = 1'b1;
                arb_off   = 4'(k);
            end
        end
    end

    assign arb_sum   = {1'b0, rr_ptr_q} + {1'b0, arb_off};
    assign arb_idx   = (arb_sum >= 5'(N_MON)) ? 4'(arb_sum - 5'(N_MON)) : arb_sum[3:0];
    assign sel_inc   = (sel_q == 4'(N_MON - 1)) ? 4'd0 : sel_q + 4'd1;
    assign sel_oh    = N_MON'(1) << sel_q;
    assign sel_valid = |(mon_valid & sel_oh);
    assign sel_elig  = |(elig & sel_oh);
    assign data_sh   = mon_data >> (32'(sel_q) * 32'd36);

`ifdef SIGMON_COLLECT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;

    always_comb begin
        tmr_d = tmr_q;
        if (state_q == READ)
            tmr_d = TMR_W'(TIMEOUT - 1);
        else if (state_q == WAIT && tmr_q != '0)
            tmr_d = tmr_q - TMR_W'(1);
    end

    assign rsp_timeout = (state_q == WAIT) && !sel_valid && (tmr_q == '0);
    assign err_d       = err_q | rsp_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign rsp_timeout = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mon_read    = '0;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        case (state_q)
            IDLE: if (collect_en && |elig) state_d = ARB;
            ARB: begin
                if (arb_found) begin
                    sel_d       = arb_idx;
                    burst_cnt_d = '0;
                    state_d     = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (!collect_en) begin
                    state_d = IDLE;
                end else if (!out_valid_q) begin
                    mon_read = sel_oh;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (sel_valid) begin
                    out_data_d  = {sel_q, data_sh[35:0]};
                    out_valid_d = 1'b1;
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                    state_d     = NEXT;
                end else if (rsp_timeout) begin
                    rr_ptr_d = sel_inc;
                    state_d  = ARB;
                end
            end
            NEXT: begin
                if (collect_en && burst_cnt_q < BC_W'(BURST) && sel_elig) begin
                    state_d = READ;
                end else begin
                    rr_ptr_d = sel_inc;
                    state_d  = collect_en ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A collect_en rising edge starts a fresh loss window.
    assign loss_d     = ((collect_en && !collect_en_q) ? '0 : loss_q) | mon_loss;
    assign word_cnt_d = (out_valid_q && out_ready) ? word_cnt_q + 32'd1 : word_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            loss_q       <= '0;
            word_cnt_q   <= '0;
            collect_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            loss_q       <= loss_d;
            word_cnt_q   <= word_cnt_d;
            collect_en_q <= collect_en;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign loss_vec  = loss_q;
    assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_sigmon_event_collector.sv
// Bench for sigmon_event_collector: FIFO-backed monitor models, a round-robin schedule model and a word scoreboard.
module tb_sigmon_event_collector;
    localparam int N     = 4;
    localparam int BURST = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            collect_en;
    logic [36*N-1:0] mon_data;
    logic [11*N-1:0] mon_count;
    logic [N-1:0]    mon_valid;
    logic [N-1:0]    mon_loss;
    logic [N-1:0]    mon_read;
    logic [39:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    loss_vec;
    logic [31:0]     word_cnt;
    logic            err_timeout;

    always #5 clk = ~clk;

    sigmon_event_collector #(.N_MON(N), .BURST(BURST), .TIMEOUT(7)) dut (
        .clk(clk), .reset(reset), .collect_en(collect_en),
        .mon_data(mon_data), .mon_count(mon_count), .mon_valid(mon_valid), .mon_loss(mon_loss),
        .mon_read(mon_read), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .loss_vec(loss_vec), .word_cnt(word_cnt), .err_timeout(err_timeout)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [35:0] fifo_q [N][$];
    logic [39:0] exp_q [$];
    int          rd_cyc [$];
    int          ready_mode, stall_left, first_word_cyc, tmo_rd;
    bit          seen_word, spur_en, drop_armed, suppress_armed;
    logic        pv, prdy;
    logic [39:0] pod;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_counts();
        for (int i = 0; i < N; i++) mon_count[11*i +: 11] = 11'(fifo_q[i].size());
    endtask

    // Schedule model: strict rotation, at most BURST words per turn, FIFOs preloaded.
    function automatic void build_exp(input int cnt_in[N]);
        int c[N];
        int pos[N];
        int ptr, sel, n, idx;
        c = cnt_in;
        ptr = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        while (1) begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (sel < 0 && c[idx] > 0) sel = idx;
            end
            if (sel < 0) break;
            n = (c[sel] < BURST) ? c[sel] : BURST;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back({4'(sel), fifo_q[sel][pos[sel]]});
                pos[sel]++;
            end
            c[sel] -= n;
            ptr = (sel + 1) % N;
        end
    endfunction

    task automatic step();
        logic [N-1:0] rd;
        logic         ov, rdy;
        logic [39:0]  od;
        int           now;
        @(negedge clk);
        rd = mon_read; ov = out_valid; od = out_data; rdy = out_ready; now = cyc;
        if (!reset) begin
            chk("read_onehot", 64'($onehot0(rd)), 64'd1);
            if (rd != '0) begin
                chk("read_while_full", 64'(ov), 64'd0);
                rd_cyc.push_back(now);
            end
            if (pv && !prdy) begin
                chk("hold_valid", 64'(ov), 64'd1);
                chk("hold_data", 64'(od), 64'(pod));
            end
            if (ov && !seen_word) begin
                seen_word = 1'b1;
                first_word_cyc = now;
                stall_left = 10;
            end
            if (ov && rdy) begin
                chk("word_in_budget", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("word", 64'(od), 64'(exp_q.pop_front()));
            end
`ifdef SIGMON_COLLECT_TIMEOUT_EN
            if (tmo_rd >= 0 && now == tmo_rd + 7) chk("tmo_early", 64'(err_timeout), 64'd0);
            if (tmo_rd >= 0 && now == tmo_rd + 8) chk("tmo_set", 64'(err_timeout), 64'd1);
`endif
        end
        pv = ov; prdy = rdy; pod = od;
        @(posedge clk);
        #1;
        cyc++;
        mon_valid = '0;
        mon_loss  = '0;
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                chk("fifo_underflow", 64'(fifo_q[i].size() != 0), 64'd1);
                if (fifo_q[i].size() != 0) mon_data[36*i +: 36] = fifo_q[i].pop_front();
                if (suppress_armed) begin
                    suppress_armed = 1'b0;
                    tmo_rd = now;
                end else begin
                    mon_valid[i] = 1'b1;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mon_valid[i] = 1'b1;
                mon_data[36*i +: 36] = 36'({$urandom(), $urandom()});
            end
        end
        if (drop_armed && rd != '0) begin
            collect_en = 1'b0;
            drop_armed = 1'b0;
        end
        update_counts();
        if (seen_word && stall_left > 0) stall_left--;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = seen_word && stall_left == 0;
        endcase
    endtask

    task automatic scenario(input int c0, input int c1, input int c2, input int c3,
                            input int mode, input bit spur, input bit drop, input bit tmo,
                            output int total);
        int cnt[N];
        logic [39:0] e;
        reset = 1'b1; collect_en = 1'b0; mon_valid = '0; mon_loss = '0; out_ready = 1'b0;
        ready_mode = mode; spur_en = 1'b0; drop_armed = 1'b0; suppress_armed = 1'b0;
        seen_word = 1'b0; stall_left = 0; first_word_cyc = -1; tmo_rd = -1; pv = 1'b0;
        exp_q.delete();
        rd_cyc.delete();
        cnt = '{c0, c1, c2, c3};
        for (int i = 0; i < N; i++) begin
            fifo_q[i].delete();
            for (int j = 0; j < cnt[i]; j++) fifo_q[i].push_back(36'({$urandom(), $urandom()}));
        end
        update_counts();
        repeat (2) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_mon_read", 64'(mon_read), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_loss_vec", 64'(loss_vec), 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        reset = 1'b0;
        build_exp(cnt);
        if (drop) begin
            e = exp_q[0];
            exp_q.delete();
            exp_q.push_back(e);
        end
`ifdef SIGMON_COLLECT_TIMEOUT_EN
        if (tmo) begin
            exp_q.delete();
            exp_q.push_back({4'd1, fifo_q[1][0]});
            exp_q.push_back({4'd1, fifo_q[1][1]});
            exp_q.push_back({4'd0, fifo_q[0][1]});
        end
`endif
        total = exp_q.size();
        spur_en = spur; drop_armed = drop; suppress_armed = tmo;
        collect_en = 1'b1;
        for (int k = 0; k < 4000 && exp_q.size() != 0; k++) step();
        repeat (12) step();
        chk("drain_complete", 64'(exp_q.size()), 64'd0);
        chk("word_cnt", 64'(word_cnt), 64'(total));
    endtask

    initial begin
        int total;
        reset = 1'b1; collect_en = 1'b0; mon_data = '0; mon_count = '0;
        mon_valid = '0; mon_loss = '0; out_ready = 1'b0;
        pv = 1'b0; prdy = 1'b0; pod = '0; tmo_rd = -1;

        // Single source: three reads three cycles apart, all tagged 2.
        scenario(0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0, total);
        chk("t1_reads", 64'(rd_cyc.size()), 64'd3);
        if (rd_cyc.size() == 3) begin
            chk("t1_gap0", 64'(rd_cyc[1] - rd_cyc[0]), 64'd3);
            chk("t1_gap1", 64'(rd_cyc[2] - rd_cyc[1]), 64'd3);
        end
        chk("t1_err_off", 64'(err_timeout), 64'd0);

        // Two full sources: alternating bursts of 8, then 4 each.
        scenario(20, 20, 0, 0, 0, 1'b0, 1'b0, 1'b0, total);
        chk("t2_total", 64'(word_cnt), 64'd40);

        // Consumer stalls for 10 cycles on the first word.
        scenario(3, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, total);
        if (rd_cyc.size() >= 2) chk("t3_read_after_accept", 64'(rd_cyc[1]), 64'(first_word_cyc + 11));
        else chk("t3_reads", 64'(rd_cyc.size()), 64'd3);

        // collect_en dropped the cycle after the first read.
        scenario(0, 5, 0, 0, 0, 1'b0, 1'b1, 1'b0, total);
        chk("t4_reads", 64'(rd_cyc.size()), 64'd1);

        // Sticky loss flag, cleared by a collect_en rising edge.
        fifo_q[1].delete();
        update_counts();
        mon_loss = 4'b1000;
        repeat (4) step();
        chk("t5_loss_sticky", 64'(loss_vec), 64'h8);
        collect_en = 1'b1;
        repeat (2) step();
        chk("t5_loss_cleared", 64'(loss_vec), 64'h0);

        // Random fill, random back-pressure, spurious valids on idle monitors.
        for (int r = 0; r < 6; r++) begin
            scenario(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                     1, 1'b1, 1'b0, 1'b0, total);
        end

`ifdef SIGMON_COLLECT_TIMEOUT_EN
        // First response suppressed: word skipped, arbitration moves to monitor 1.
        scenario(2, 2, 0, 0, 0, 1'b0, 1'b0, 1'b1, total);
        chk("t6_err_sticky", 64'(err_timeout), 64'd1);
        chk("t6_reads", 64'(rd_cyc.size()), 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
